// File: rtl/i2c_codec_slave.sv
// Write-only I2C target shadowing the audio codec control port: decodes
// 3-byte {addr, reg/data8, data[7:0]} frames into a 10 x 9-bit register file.
module i2c_codec_slave #(
   parameter logic [6:0] SLAVE_ADDR = 7'h1A
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic        I2C_SCLK,
   inout  wire         I2C_SDAT,
   output logic        oREG_WE,
   output logic [6:0]  oREG_ADDR,
   output logic [8:0]  oREG_DATA,
   output logic [89:0] oREGS,
   output logic        oBUSY
);

   localparam logic [89:0] DEFAULTS = {9'h000, 9'h000, 9'h00A, 9'h09F, 9'h008,
                                       9'h00A, 9'h079, 9'h079, 9'h097, 9'h097};

   typedef enum logic [2:0] {IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE} state_t;

   state_t      stateReg, stateNext;
   logic [3:0]  bitCntReg, bitCntNext;
   logic [7:0]  shiftReg, shiftNext;
   logic [7:0]  byte1Reg, byte1Next;
   logic        sdaLowReg, sdaLowNext;
   logic        commit;
   logic [1:0]  sclSync, sdaSync;
   logic        sclDly, sdaDly;
   logic        sclRise, sclFall, startCond, stopCond;
   logic [6:0]  commitAddr;
   logic [8:0]  commitData;
   logic [8:0]  regFile [10];

   // Flops reset to 1 so the idle bus never looks like an edge after reset.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         sclSync <= 2'b11;
         sdaSync <= 2'b11;
         sclDly  <= 1'b1;
         sdaDly  <= 1'b1;
      end else begin
         sclSync <= {sclSync[0], I2C_SCLK};
         sdaSync <= {sdaSync[0], I2C_SDAT};
         sclDly  <= sclSync[1];
         sdaDly  <= sdaSync[1];
      end
   end

   assign sclRise   = sclSync[1] & ~sclDly;
   assign sclFall   = ~sclSync[1] & sclDly;
   assign startCond = sclSync[1] & sclDly & sdaDly & ~sdaSync[1];
   assign stopCond  = sclSync[1] & sclDly & ~sdaDly & sdaSync[1];

   assign I2C_SDAT  = sdaLowReg ? 1'b0 : 1'bz;
   assign oBUSY     = (stateReg != IDLE) && (stateReg != IGNORE);
   assign commitAddr = byte1Reg[7:1];
   assign commitData = {byte1Reg[0], shiftReg};

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         stateReg  <= IDLE;
         bitCntReg <= '0;
         shiftReg  <= '0;
         byte1Reg  <= '0;
         sdaLowReg <= 1'b0;
      end else begin
         stateReg  <= stateNext;
         bitCntReg <= bitCntNext;
         shiftReg  <= shiftNext;
         byte1Reg  <= byte1Next;
         sdaLowReg <= sdaLowNext;
      end
   end

   always_comb begin
      stateNext  = stateReg;
      bitCntNext = bitCntReg;
      shiftNext  = shiftReg;
      byte1Next  = byte1Reg;
      sdaLowNext = sdaLowReg;
      commit     = 1'b0;
      if (startCond) begin
         stateNext  = ADDR;
         bitCntNext = '0;
         shiftNext  = '0;
         sdaLowNext = 1'b0;
      end else if (stopCond) begin
         stateNext  = IDLE;
         sdaLowNext = 1'b0;
      end else begin
         case (stateReg)
            ADDR, BYTE1, BYTE2: begin
               if (sclRise && bitCntReg != 4'd8) begin
                  shiftNext  = {shiftReg[6:0], sdaSync[1]};
                  bitCntNext = bitCntReg + 4'd1;
               end else if (sclFall && bitCntReg == 4'd8) begin
                  bitCntNext = '0;
                  if (stateReg == ADDR) begin
                     if (shiftReg == {SLAVE_ADDR, 1'b0}) begin
                        stateNext  = ACK_A;
                        sdaLowNext = 1'b1;
                     end else begin
                        stateNext = IGNORE;
                     end
                  end else if (stateReg == BYTE1) begin
                     byte1Next  = shiftReg;
                     stateNext  = ACK_1;
                     sdaLowNext = 1'b1;
                  end else begin
                     stateNext  = ACK_2;
                     sdaLowNext = 1'b1;
                  end
               end
            end
            ACK_A, ACK_1: begin
               if (sclFall) begin
                  sdaLowNext = 1'b0;
                  stateNext  = (stateReg == ACK_A) ? BYTE1 : BYTE2;
                  shiftNext  = '0;
                  bitCntNext = '0;
               end
            end
            ACK_2: begin
               // byte2 is still in shiftReg here; commit uses it directly
               if (sclFall) begin
                  sdaLowNext = 1'b0;
                  stateNext  = IGNORE;
                  commit     = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         oREG_WE   <= 1'b0;
         oREG_ADDR <= '0;
         oREG_DATA <= '0;
         for (int i = 0; i < 10; i++) regFile[i] <= DEFAULTS[i*9 +: 9];
      end else begin
         oREG_WE <= commit;
         if (commit) begin
            oREG_ADDR <= commitAddr;
            oREG_DATA <= commitData;
            if (commitAddr == 7'h0F) begin
               for (int i = 0; i < 10; i++) regFile[i] <= DEFAULTS[i*9 +: 9];
            end else if (commitAddr < 7'd10) begin
               regFile[commitAddr[3:0]] <= commitData;
            end
         end
      end
   end

   always_comb begin
      oREGS = '0;
      for (int i = 0; i < 10; i++) oREGS[i*9 +: 9] = regFile[i];
   end

endmodule

// File: tb/tb_i2c_codec_slave.sv
// Directed bench: an open-drain I2C master drives frames, a scoreboard
// monitor checks every oREG_WE pulse against hand-computed expectations.
module tb_i2c_codec_slave;

   logic        iCLK = 1'b0;
   logic        iRST_N = 1'b0;
   logic        sclDrv = 1'b1;
   logic        mstLow = 1'b0;
   wire         sdaBus;
   logic        oREG_WE;
   logic [6:0]  oREG_ADDR;
   logic [8:0]  oREG_DATA;
   logic [89:0] oREGS;
   logic        oBUSY;

   assign sdaBus = mstLow ? 1'b0 : 1'bz;
   pullup (sdaBus);

   always #5 iCLK = ~iCLK;

   i2c_codec_slave dut (
      .iCLK      (iCLK),
      .iRST_N    (iRST_N),
      .I2C_SCLK  (sclDrv),
      .I2C_SDAT  (sdaBus),
      .oREG_WE   (oREG_WE),
      .oREG_ADDR (oREG_ADDR),
      .oREG_DATA (oREG_DATA),
      .oREGS     (oREGS),
      .oBUSY     (oBUSY)
   );

   typedef struct packed {
      logic [6:0]  addr;
      logic [8:0]  data;
      logic [89:0] regs;
   } exp_t;

   exp_t       expQ[$];
   logic [8:0] modelRegs [10];
   int         total = 0;
   int         bad = 0;

   task automatic check(input string name, input logic [89:0] act, input logic [89:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic modelDefaults();
      modelRegs = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                    9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
   endtask

   function automatic logic [89:0] packModel();
      logic [89:0] v;
      v = '0;
      for (int i = 0; i < 10; i++) v[i*9 +: 9] = modelRegs[i];
      return v;
   endfunction

   task automatic expectWrite(input logic [6:0] a, input logic [8:0] d);
      if (a == 7'h0F) modelDefaults();
      else if (a < 7'd10) modelRegs[a[3:0]] = d;
      expQ.push_back(exp_t'({a, d, packModel()}));
   endtask

   always @(negedge iCLK) begin
      exp_t e;
      if (oREG_WE === 1'b1) begin
         if (expQ.size() == 0) begin
            check("unexpected_we", {89'b0, oREG_WE}, 90'b0);
         end else begin
            e = expQ.pop_front();
            $display("write addr=%h data=%h", oREG_ADDR, oREG_DATA);
            check("we_addr", {83'b0, oREG_ADDR}, {83'b0, e.addr});
            check("we_data", {81'b0, oREG_DATA}, {81'b0, e.data});
            check("we_regs", oREGS, e.regs);
         end
      end
   end

   task automatic hw();
      repeat (20) @(posedge iCLK);
      #1;
   endtask

   task automatic i2cStart();
      mstLow = 1'b0; hw();
      sclDrv = 1'b1; hw();
      mstLow = 1'b1; hw();
      sclDrv = 1'b0; hw();
   endtask

   task automatic i2cStop();
      mstLow = 1'b1; hw();
      sclDrv = 1'b1; hw();
      mstLow = 1'b0; hw();
   endtask

   task automatic sendBits(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         mstLow = ~b[i]; hw();
         sclDrv = 1'b1;  hw();
         sclDrv = 1'b0;  hw();
      end
   endtask

   task automatic sendByte(input logic [7:0] b, input logic expAck, input string name);
      logic ack;
      sendBits(b);
      mstLow = 1'b0; hw();
      sclDrv = 1'b1;
      repeat (10) @(posedge iCLK);
      #1;
      ack = (sdaBus === 1'b0);
      check(name, {89'b0, ack}, {89'b0, expAck});
      repeat (10) @(posedge iCLK);
      #1;
      sclDrv = 1'b0; hw();
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      modelDefaults();
      iRST_N = 1'b0;
      repeat (5) @(posedge iCLK);
      #1 iRST_N = 1'b1;
      hw();
      check("rst_r0", {81'b0, oREGS[8:0]}, 90'h097);
      check("rst_r6", {81'b0, oREGS[62:54]}, 90'h09F);
      check("rst_all", oREGS, packModel());
      check("rst_busy", {89'b0, oBUSY}, 90'h0);
      check("rst_sda", {89'b0, sdaBus}, 90'h1);
      check("rst_we", {89'b0, oREG_WE}, 90'h0);
      check("rst_addr_data", {74'b0, oREG_ADDR, oREG_DATA}, 90'h0);

      // analogue path ctrl, plus a 4th byte that must be NACKed
      i2cStart();
      check("busy_after_start", {89'b0, oBUSY}, 90'h1);
      sendByte(8'h34, 1'b1, "f1_ack_addr");
      sendByte(8'h08, 1'b1, "f1_ack_b1");
      expectWrite(7'h04, 9'h028);
      sendByte(8'h28, 1'b1, "f1_ack_b2");
      check("f1_busy_ignore", {89'b0, oBUSY}, 90'h0);
      sendByte(8'h55, 1'b0, "f1_nack_b3");
      i2cStop();
      check("f1_r4", {81'b0, oREGS[44:36]}, 90'h028);

      // R7 write, then reset-register write restores defaults
      i2cStart();
      sendByte(8'h34, 1'b1, "f2_ack_addr");
      sendByte(8'h0E, 1'b1, "f2_ack_b1");
      expectWrite(7'h07, 9'h001);
      sendByte(8'h01, 1'b1, "f2_ack_b2");
      i2cStop();
      check("f2_r7", {81'b0, oREGS[71:63]}, 90'h001);
      i2cStart();
      sendByte(8'h34, 1'b1, "f3_ack_addr");
      sendByte(8'h1E, 1'b1, "f3_ack_b1");
      expectWrite(7'h0F, 9'h000);
      sendByte(8'h00, 1'b1, "f3_ack_b2");
      i2cStop();
      check("f3_defaults", oREGS, packModel());

      // out-of-range register: ACKed, pulses, file unchanged
      i2cStart();
      sendByte(8'h34, 1'b1, "f4_ack_addr");
      sendByte(8'h14, 1'b1, "f4_ack_b1");
      expectWrite(7'h0A, 9'h033);
      sendByte(8'h33, 1'b1, "f4_ack_b2");
      i2cStop();

      // wrong address and read bit
      i2cStart();
      sendByte(8'h36, 1'b0, "f5_nack_addr36");
      check("f5_busy_ignore", {89'b0, oBUSY}, 90'h0);
      sendByte(8'h08, 1'b0, "f5_nack_b1");
      sendByte(8'h28, 1'b0, "f5_nack_b2");
      i2cStop();
      i2cStart();
      sendByte(8'h35, 1'b0, "f6_nack_addr35");
      i2cStop();
      check("f6_regs_unchanged", oREGS, packModel());

      // aborted frame, then a repeated START carrying a full frame
      i2cStart();
      sendByte(8'h34, 1'b1, "f7_ack_addr");
      sendByte(8'h0C, 1'b1, "f7_ack_b1");
      i2cStop();
      check("f7_no_write", oREGS, packModel());
      i2cStart();
      sendByte(8'h34, 1'b1, "f8_ack_addr");
      sendByte(8'h0C, 1'b1, "f8_ack_b1");
      i2cStart();
      sendByte(8'h34, 1'b1, "f8_ack_addr_rs");
      sendByte(8'h0C, 1'b1, "f8_ack_b1_rs");
      expectWrite(7'h06, 9'h000);
      sendByte(8'h00, 1'b1, "f8_ack_b2_rs");
      i2cStop();
      check("f8_r6", {81'b0, oREGS[62:54]}, 90'h000);

      // reset asserted while the slave is ACKing byte 1
      i2cStart();
      sendByte(8'h34, 1'b1, "f9_ack_addr");
      sendBits(8'h0C);
      mstLow = 1'b0; hw();
      sclDrv = 1'b1;
      repeat (5) @(posedge iCLK);
      #1;
      check("f9_ack1_held", {89'b0, sdaBus}, 90'h0);
      iRST_N = 1'b0;
      #1;
      check("f9_rst_release", {89'b0, sdaBus}, 90'h1);
      modelDefaults();
      repeat (5) @(posedge iCLK);
      #1 sclDrv = 1'b0; hw();
      iRST_N = 1'b1; hw();
      check("f9_defaults", oREGS, packModel());
      check("f9_busy", {89'b0, oBUSY}, 90'h0);
      i2cStop();
      i2cStart();
      sendByte(8'h34, 1'b1, "f10_ack_addr");
      sendByte(8'h02, 1'b1, "f10_ack_b1");
      expectWrite(7'h01, 9'h05A);
      sendByte(8'h5A, 1'b1, "f10_ack_b2");
      i2cStop();
      check("f10_r1", {81'b0, oREGS[17:9]}, 90'h05A);

      repeat (50) @(posedge iCLK);
      check("queue_empty", 90'(expQ.size()), 90'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2c_codec_slave.md
# i2c_codec_slave

I2C write-only responder modelling the control port of the audio codec at 7-bit address 0x1A (write byte 0x34). It accepts the 3-byte frames produced by the codec configuration master: address, then {reg[6:0], data[8]}, then data[7:0]. It maintains a 10 x 9-bit register file with codec power-on defaults. It serves as the self-checking bus target in configuration benches and as an on-chip shadow of codec settings.

## Interface
- SLAVE_ADDR, 7'h1A, 7-bit address answered; R/W bit must be 0
- iCLK  in  1  system clock, at least 16x the SCL frequency
- iRST_N  in  1  reset; asynchronous, active-low
- I2C_SCLK  in  1  bus clock from the master, asynchronous to iCLK
- I2C_SDAT  inout  1  open-drain data; block drives only 0 or Z
- oREG_WE  out  1  one-cycle pulse when a frame completes
- oREG_ADDR  out  7  register address of the last completed frame
- oREG_DATA  out  9  data of the last completed frame
- oREGS  out  90  register file, R0 in [8:0] up to R9 in [89:81]
- oBUSY  out  1  high from START until STOP or abort

## Operation
- Sync SCL and SDA through two flops, then register once more for edge detection. All decisions use the synchronized values.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are recognised in every state.
- START (repeated start included) enters ADDR and clears the bit counter and shift register. STOP enters IDLE and discards any partial frame.
- States:
  - IDLE
  - ADDR: 8 bits
  - ACK_A
  - BYTE1: 8 bits
  - ACK_1
  - BYTE2: 8 bits
  - ACK_2
  - IGNORE: SDA stays released until the next START or STOP
- Bits are shifted MSB first on SCL rising edges.
- ADDR ends on the 8th SCL falling edge:
  - If {SLAVE_ADDR,0} matches, go to ACK_A and pull SDA low.
  - Otherwise go to IGNORE.
- ACK states hold SDA low until the next SCL falling edge, then release it and advance. ACK_2 then goes to IGNORE, so any 4th byte is NACKed.
- Commit happens on the SCL falling edge that ends ACK_2:
  - addr = byte1[7:1], data = {byte1[0], byte2}.
  - oREG_WE pulses and oREG_ADDR/oREG_DATA load.
  - addr 0..9: that register takes data.
  - addr 0x0F (reset register): all registers return to defaults, whatever the data value.
  - Any other address: the frame is ACKed, oREG_WE still pulses, and the file is unchanged.
- Defaults R0..R9: 097, 097, 079, 079, 00A, 008, 09F, 00A, 000, 000 (hex).
- Reset values: oREG_WE=0, oREG_ADDR=0, oREG_DATA=0, oBUSY=0, SDA released (Z), state IDLE, oREGS=defaults.
- Reset mid-frame releases SDA asynchronously. The partial frame is lost, and the block waits for a fresh START.

## Timing
- Input latency: 2 sync cycles plus 1 edge-detect cycle. Each SCL/SDA event is acted on 3 iCLK cycles after the pin changes.
- SDA pull-down or release happens at most 4 iCLK cycles after SCL falls. This requires an SCL low phase of at least 8 iCLK cycles. The 20 kHz master on a 25 MHz clock gives about 625 cycles.
- The following all become valid on the same iCLK edge:
  - the oREG_WE pulse
  - oREG_ADDR/oREG_DATA
  - the updated oREGS
- oREG_WE is exactly 1 cycle wide and never asserts for NACKed or aborted frames.
- oBUSY rises 3 cycles after the START condition on the pins. It falls 3 cycles after STOP, or on entry to IGNORE.
- SDA changes while SCL is high are START/STOP only, never data. Data bits sampled on the SCL rising edge must be stable through the SCL high phase.

## Test plan
- After reset: oREGS R0=097 and R6=09F, oBUSY=0, SDA=Z.
- Frame 34, 08, 28 (analogue path ctrl) -> ACK on all 3 bytes, one oREG_WE pulse, oREG_ADDR=04, oREG_DATA=028, R4=028.
- Frames 34, 0E, 01 then 34, 1E, 00 -> R7=001, then all registers back to defaults after the write to R15.
- Address byte 36 or 35 -> no ACK on byte 1, no oREG_WE, oREGS unchanged, oBUSY=0 after IGNORE.
- STOP after byte 2 (34, 0C only) -> no oREG_WE. A following repeated START with 34, 0C, 00 -> R6=000.
- Assert iRST_N low during ACK_1 -> SDA released in the same cycle, registers return to defaults, the next full frame is accepted normally.
